// File: rtl/bonus_slot_allocator.sv
// bonus_slot_allocator: round-robin allocator for the falling-bonus object slots.
// Optional per-slot frame lifetime expiry is compiled in when BONUS_LIFETIME_EN is defined.
module bonus_slot_allocator #(
  parameter int NUM_SLOTS       = 16,
  parameter int LIFETIME_FRAMES = 240
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 spawn_req,
  output logic                 spawn_ack,
  output logic                 spawn_drop,
  output logic [3:0]           spawn_slot,
  output logic                 spawn_busy,
  input  logic [NUM_SLOTS-1:0] release_req,
  output logic [NUM_SLOTS-1:0] slot_active,
  output logic [NUM_SLOTS-1:0] slot_start,
  output logic [4:0]           active_count
);

  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  // state | meaning
  // IDLE  | waiting for spawn_req
  // SCAN  | probing one slot per cycle, starting at rr_ptr
  // DONE  | ack or drop visible; spawn_req ignored; back to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        scan_idx;
  logic [IW-1:0]        probe_cnt;
  logic                 probe_free;
  logic                 last_probe;
  logic [NUM_SLOTS-1:0] grant_mask;
  logic [NUM_SLOTS-1:0] expire_mask;
  logic [4:0]           pop_next;

  // Probe the registered slot state, so a release that landed earlier in the scan is visible.
  assign probe_free = ~slot_active[scan_idx];
  assign last_probe = (probe_cnt == IW'(NUM_SLOTS - 1));
  assign grant_mask = (state == SCAN && probe_free) ? (NUM_SLOTS'(1) << scan_idx) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      scan_idx   <= '0;
      probe_cnt  <= '0;
      spawn_ack  <= 1'b0;
      spawn_drop <= 1'b0;
      spawn_slot <= '0;
      spawn_busy <= 1'b0;
      slot_start <= '0;
    end else begin
      spawn_ack  <= 1'b0;
      spawn_drop <= 1'b0;
      spawn_slot <= '0;
      slot_start <= '0;
      case (state)
        IDLE: begin
          if (spawn_req) begin
            state      <= SCAN;
            scan_idx   <= rr_ptr;
            probe_cnt  <= '0;
            spawn_busy <= 1'b1;
          end
        end
        SCAN: begin
          if (probe_free) begin
            state      <= DONE;
            spawn_ack  <= 1'b1;
            spawn_slot <= 4'(scan_idx);
            slot_start <= grant_mask;
            rr_ptr     <= scan_idx + IW'(1);
          end else if (last_probe) begin
            state      <= DONE;
            spawn_drop <= 1'b1;
          end else begin
            scan_idx  <= scan_idx + IW'(1);
            probe_cnt <= probe_cnt + IW'(1);
          end
        end
        DONE: begin
          state      <= IDLE;
          spawn_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          spawn_busy <= 1'b0;
        end
      endcase
    end
  end

  // Grant is OR'd last: a granted slot was inactive, so a coincident release is a no-op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_active <= '0;
    end else begin
      slot_active <= (slot_active & ~release_req & ~expire_mask) | grant_mask;
    end
  end

  always_comb begin
    pop_next = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      pop_next = pop_next + 5'(slot_active[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_count <= '0;
    end else begin
      active_count <= pop_next;
    end
  end

`ifdef BONUS_LIFETIME_EN
  logic [7:0] life_cnt [NUM_SLOTS];

  // Expiry fires on the same edge as the increment that reaches the lifetime.
  always_comb begin
    expire_mask = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (startOfFrame && slot_active[i] &&
          ((life_cnt[i] + 8'd1) == 8'(LIFETIME_FRAMES))) begin
        expire_mask[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        life_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (grant_mask[i]) begin
          life_cnt[i] <= '0;
        end else if (startOfFrame && slot_active[i]) begin
          life_cnt[i] <= expire_mask[i] ? 8'd0 : life_cnt[i] + 8'd1;
        end
      end
    end
  end
`else
  logic sof_unused;
  assign sof_unused  = startOfFrame;
  assign expire_mask = '0;
`endif

endmodule

// File: tb/tb_bonus_slot_allocator.sv
// Directed testbench for bonus_slot_allocator; lifetime expectations follow BONUS_LIFETIME_EN.
module tb_bonus_slot_allocator;

`ifdef BONUS_LIFETIME_EN
  localparam bit LIFETIME_EN = 1'b1;
`else
  localparam bit LIFETIME_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic        spawn_req;
  logic        spawn_ack;
  logic        spawn_drop;
  logic [3:0]  spawn_slot;
  logic        spawn_busy;
  logic [15:0] release_req;
  logic [15:0] slot_active;
  logic [15:0] slot_start;
  logic [4:0]  active_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bonus_slot_allocator #(
    .NUM_SLOTS       (16),
    .LIFETIME_FRAMES (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .spawn_req    (spawn_req),
    .spawn_ack    (spawn_ack),
    .spawn_drop   (spawn_drop),
    .spawn_slot   (spawn_slot),
    .spawn_busy   (spawn_busy),
    .release_req  (release_req),
    .slot_active  (slot_active),
    .slot_start   (slot_start),
    .active_count (active_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    spawn_req = 1'b0;
    startOfFrame = 1'b0;
    release_req = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Raise spawn_req in the current cycle k; lat counts cycles until ack/drop is seen.
  task automatic do_spawn(input logic [15:0] rel_mask, output int lat,
                          output logic got_ack, output logic got_drop,
                          output logic [3:0] slot, output logic [15:0] start_at,
                          output logic [15:0] start_after);
    lat = 0;
    got_ack = 1'b0;
    got_drop = 1'b0;
    slot = '0;
    start_at = '0;
    spawn_req = 1'b1;
    while (!got_ack && !got_drop && lat < 40) begin
      tick();
      lat++;
      release_req = (lat == 1) ? rel_mask : 16'h0000;
      if (spawn_ack) begin
        got_ack = 1'b1;
        slot = spawn_slot;
        start_at = slot_start;
      end
      if (spawn_drop) begin
        got_drop = 1'b1;
        start_at = slot_start;
      end
    end
    spawn_req = 1'b0;
    release_req = '0;
    tick();
    start_after = slot_start | {15'd0, spawn_ack | spawn_drop};
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({spawn_ack, spawn_drop, spawn_busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ack/drop/busy=%b, want 000", {spawn_ack, spawn_drop, spawn_busy});
    end
    n_checks++;
    if (slot_active !== 16'h0000 || slot_start !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_slots: got active=%h start=%h, want 0000/0000", slot_active, slot_start);
    end
    n_checks++;
    if (active_count !== 5'd0 || spawn_slot !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_count: got count=%0d slot=%0d, want 0/0", active_count, spawn_slot);
    end
  endtask

  task automatic test_first_spawn();
    int lat;
    logic ga, gd;
    logic [3:0] s;
    logic [15:0] st, sa;
    do_spawn(16'h0, lat, ga, gd, s, st, sa);
    n_checks++;
    if (!ga || lat != 2) begin
      n_fail++;
      $display("FAIL first_latency: got ack=%b lat=%0d, want ack=1 lat=2", ga, lat);
    end
    n_checks++;
    if (s !== 4'd0 || st !== 16'h0001) begin
      n_fail++;
      $display("FAIL first_slot: got slot=%0d start=%h, want 0/0001", s, st);
    end
    n_checks++;
    if (sa !== 16'h0000) begin
      n_fail++;
      $display("FAIL first_pulse_width: got start/ack after=%h, want 0000", sa);
    end
    n_checks++;
    if (active_count !== 5'd1 || slot_active !== 16'h0001 || spawn_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL first_count: got count=%0d active=%h busy=%b, want 1/0001/0",
               active_count, slot_active, spawn_busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic ga, gd;
    logic [3:0] s;
    logic [15:0] st, sa;
    for (int i = 1; i <= 2; i++) begin
      do_spawn(16'h0, lat, ga, gd, s, st, sa);
      n_checks++;
      if (!ga || s !== 4'(i) || lat != 2 || st !== (16'h1 << i)) begin
        n_fail++;
        $display("FAIL b2b_slot%0d: got ack=%b slot=%0d lat=%0d start=%h", i, ga, s, lat, st);
      end
    end
    release_req = 16'h0002;
    tick();
    release_req = '0;
    n_checks++;
    if (slot_active !== 16'h0005) begin
      n_fail++;
      $display("FAIL b2b_release: got active=%h, want 0005", slot_active);
    end
    do_spawn(16'h0, lat, ga, gd, s, st, sa);
    n_checks++;
    if (!ga || s !== 4'd3 || lat != 2) begin
      n_fail++;
      $display("FAIL b2b_round_robin: got ack=%b slot=%0d lat=%0d, want 1/3/2", ga, s, lat);
    end
    n_checks++;
    if (slot_active !== 16'h000D || active_count !== 5'd3) begin
      n_fail++;
      $display("FAIL b2b_active: got active=%h count=%0d, want 000d/3", slot_active, active_count);
    end
  endtask

  task automatic test_full();
    int lat;
    logic ga, gd;
    logic [3:0] s;
    logic [15:0] st, sa;
    int bad;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      do_spawn(16'h0, lat, ga, gd, s, st, sa);
      if (!ga || s !== 4'(i) || lat != 2) bad++;
    end
    n_checks++;
    if (bad != 0 || slot_active !== 16'hFFFF || active_count !== 5'd16) begin
      n_fail++;
      $display("FAIL full_fill: got bad=%0d active=%h count=%0d, want 0/ffff/16",
               bad, slot_active, active_count);
    end
    do_spawn(16'h0, lat, ga, gd, s, st, sa);
    n_checks++;
    if (!gd || ga || lat != 17) begin
      n_fail++;
      $display("FAIL full_drop: got drop=%b ack=%b lat=%0d, want 1/0/17", gd, ga, lat);
    end
    n_checks++;
    if (st !== 16'h0000 || sa !== 16'h0000 || slot_active !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL full_no_start: got start=%h after=%h active=%h, want 0000/0000/ffff",
               st, sa, slot_active);
    end
    release_req = 16'h0020;
    tick();
    release_req = '0;
    // rr_ptr left at 0 by the drop, so slot 5 is hit on probe 5.
    do_spawn(16'h0, lat, ga, gd, s, st, sa);
    n_checks++;
    if (!ga || s !== 4'd5 || lat != 7 || st !== 16'h0020) begin
      n_fail++;
      $display("FAIL full_refill: got ack=%b slot=%0d lat=%0d start=%h, want 1/5/7/0020",
               ga, s, lat, st);
    end
  endtask

  task automatic test_release_during_scan();
    int lat;
    logic ga, gd;
    logic [3:0] s;
    logic [15:0] st, sa;
    // All busy, rr_ptr=6: slot 7 is released while slot 6 is being probed.
    do_spawn(16'h0080, lat, ga, gd, s, st, sa);
    n_checks++;
    if (!ga || gd || s !== 4'd7 || lat != 3) begin
      n_fail++;
      $display("FAIL scan_release: got ack=%b drop=%b slot=%0d lat=%0d, want 1/0/7/3",
               ga, gd, s, lat);
    end
    n_checks++;
    if (slot_active !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL scan_release_active: got active=%h, want ffff", slot_active);
    end
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    spawn_req = 1'b1;
    tick();
    tick();
    tick();
    n_checks++;
    if (spawn_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midscan_busy: got busy=%b, want 1", spawn_busy);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (slot_active !== 16'h0000 || active_count !== 5'd0 || spawn_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midscan_reset: got active=%h count=%0d busy=%b, want 0000/0/0",
               slot_active, active_count, spawn_busy);
    end
    spawn_req = 1'b0;
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (spawn_ack || spawn_drop || slot_start != 16'h0) seen++;
    end
    n_checks++;
    if (seen != 0 || slot_active !== 16'h0000) begin
      n_fail++;
      $display("FAIL midscan_quiet: got stray pulses=%0d active=%h, want 0/0000", seen, slot_active);
    end
  endtask

  task automatic test_lifetime();
    int lat;
    logic ga, gd;
    logic [3:0] s;
    logic [15:0] st, sa;
    logic exp_bit;
    apply_reset();
    do_spawn(16'h0, lat, ga, gd, s, st, sa);
    n_checks++;
    if (!ga || s !== 4'd0) begin
      n_fail++;
      $display("FAIL life_grant: got ack=%b slot=%0d, want 1/0", ga, s);
    end
    for (int p = 1; p <= 3; p++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      exp_bit = (p == 3 && LIFETIME_EN) ? 1'b0 : 1'b1;
      n_checks++;
      if (slot_active[0] !== exp_bit) begin
        n_fail++;
        $display("FAIL life_frame%0d: got active[0]=%b, want %b", p, slot_active[0], exp_bit);
      end
      tick();
      tick();
    end
    n_checks++;
    if (active_count !== (LIFETIME_EN ? 5'd0 : 5'd1)) begin
      n_fail++;
      $display("FAIL life_count: got count=%0d, want %0d", active_count, LIFETIME_EN ? 0 : 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    spawn_req = 1'b0;
    startOfFrame = 1'b0;
    release_req = '0;
    test_reset();
    test_first_spawn();
    test_back_to_back();
    test_full();
    test_release_during_scan();
    test_reset_mid_scan();
    test_lifetime();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
